// File: rtl/uart_packet_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_packet_parser
// Function : Hunts SYNC/LEN/payload/CSUM frames from the UART receiver,
//            verifies the checksum and streams good payloads out.
// Revision : 1.0 - initial release
// ============================================================================
module uart_packet_parser #(
  parameter int              DW             = 8,
  parameter logic [DW-1:0]   SYNC_BYTE      = 8'hA5,
  parameter int              MAX_LEN        = 16,
  parameter int              TIMEOUT_CYCLES = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_data_ready,
  input  logic [DW-1:0] rx_par,
  output logic          rx_akn,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          err_len,
  output logic          err_csum,
  output logic          err_timeout
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [IW-1:0] c_IDX_ONE  = IW'(1);
  localparam logic [TW-1:0] c_TMO_ONE  = TW'(1);
  localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] c_MAX_LEN  = DW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HUNT    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CSUM    = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_len;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_rd;
  logic [7:0]      r_sum;
  logic [TW-1:0]   r_tmo;
  logic [DW-1:0]   r_buf [2**AW];
  logic            r_err_len;
  logic            r_err_csum;
  logic            r_err_tmo;

  logic            w_acc;
  logic            w_in_frame;
  logic            w_tmo_hit;
  logic            w_len_bad;
  logic [7:0]      w_sum_next;
  logic [IW-1:0]   w_len_m1;
  logic            w_err_len;
  logic            w_err_csum;
  logic            w_err_tmo;

  assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CSUM);
  assign w_acc      = rx_data_ready && (w_in_frame || (r_state == S_HUNT));
  assign w_tmo_hit  = w_in_frame && (r_tmo == c_TMO_LAST);
  assign w_len_bad  = (rx_par == '0) || (rx_par > c_MAX_LEN);
  assign w_sum_next = r_sum + rx_par[7:0];
  assign w_len_m1   = r_len - c_IDX_ONE;

  assign err_len     = r_err_len;
  assign err_csum    = r_err_csum;
  assign err_timeout = r_err_tmo;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    rx_akn     = w_acc;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = '0;
    w_err_len  = 1'b0;
    w_err_csum = 1'b0;
    w_err_tmo  = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (w_acc && (rx_par == SYNC_BYTE)) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_acc) begin
          w_next    = w_len_bad ? S_HUNT : S_PAYLOAD;
          w_err_len = w_len_bad;
        end else if (w_tmo_hit) begin
          w_next    = S_HUNT;
          w_err_tmo = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (w_acc) begin
          if (r_idx == w_len_m1) w_next = S_CSUM;
        end else if (w_tmo_hit) begin
          w_next    = S_HUNT;
          w_err_tmo = 1'b1;
        end
      end
      S_CSUM: begin
        if (w_acc) begin
          w_next     = (w_sum_next == 8'd0) ? S_DRAIN : S_HUNT;
          w_err_csum = (w_sum_next != 8'd0);
        end else if (w_tmo_hit) begin
          w_next    = S_HUNT;
          w_err_tmo = 1'b1;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = r_buf[r_rd[AW-1:0]];
        out_last  = (r_rd == w_len_m1);
        if (out_ready && (r_rd == w_len_m1)) w_next = S_HUNT;
      end
      default: w_next = S_HUNT;
    endcase
  end

  // Counter restarts on any consumed byte or state change, so it only measures silence.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len      <= '0;
      r_idx      <= '0;
      r_rd       <= '0;
      r_sum      <= '0;
      r_tmo      <= '0;
      r_err_len  <= 1'b0;
      r_err_csum <= 1'b0;
      r_err_tmo  <= 1'b0;
    end else begin
      r_err_len  <= w_err_len;
      r_err_csum <= w_err_csum;
      r_err_tmo  <= w_err_tmo;
      if (w_acc || !w_in_frame || (w_next != r_state)) begin
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + c_TMO_ONE;
      end
      case (r_state)
        S_HUNT: begin
          if (w_acc && (rx_par == SYNC_BYTE)) r_sum <= '0;
        end
        S_LEN: begin
          if (w_acc) begin
            r_sum <= rx_par[7:0];
            r_len <= rx_par[IW-1:0];
            r_idx <= '0;
          end
        end
        S_PAYLOAD: begin
          if (w_acc) begin
            r_sum <= w_sum_next;
            r_idx <= r_idx + c_IDX_ONE;
          end
        end
        S_CSUM: begin
          if (w_acc) begin
            r_sum <= w_sum_next;
            r_rd  <= '0;
          end
        end
        S_DRAIN: begin
          if (out_ready) r_rd <= r_rd + c_IDX_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_PAYLOAD) && w_acc) begin
      r_buf[r_idx[AW-1:0]] <= rx_par;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_packet_parser
// Function : Randomized and directed frames against a stream-level frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_packet_parser;

  localparam int         MAX_LEN = 16;
  localparam int         TMO     = 50;
  localparam logic [7:0] SYNC    = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_data_ready = 1'b0;
  logic [7:0] rx_par = 8'h00;
  logic       out_ready = 1'b0;
  logic       rx_akn, out_valid, out_last, err_len, err_csum, err_timeout;
  logic [7:0] out_data;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_len_n = 0, exp_csum_n = 0, exp_tmo_n = 0;
  int obs_len_n = 0, obs_csum_n = 0, obs_tmo_n = 0;
  int n_cons = 0;
  bit rnd_ready = 1'b0;

  logic [7:0] stim_q[$];
  logic [8:0] exp_q[$];

  uart_packet_parser #(
    .DW(8), .SYNC_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data_ready(rx_data_ready), .rx_par(rx_par),
    .rx_akn(rx_akn), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .err_len(err_len),
    .err_csum(err_csum), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output scoreboard, error pulse counters and backpressure hold checks.
  logic       prev_hold = 1'b0;
  logic       prev_rst  = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    logic [8:0] e;
    if (rx_data_ready && rx_akn) n_cons++;
    if (err_len)     obs_len_n++;
    if (err_csum)    obs_csum_n++;
    if (err_timeout) obs_tmo_n++;
    check("err_onehot", 32'($countones({err_len, err_csum, err_timeout}) > 1), 32'd0);
    if (prev_hold && rst && prev_rst) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(prev_data));
    end
    if (out_valid && out_ready) begin
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[7:0]));
        check("out_last", 32'(out_last), 32'(e[8]));
      end
    end
    prev_hold = out_valid && !out_ready;
    prev_data = out_data;
    prev_rst  = rst;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Stream-level model: walk the byte array frame by frame using lengths.
  task automatic model_push();
    int i = 0;
    int L, s;
    while (i < stim_q.size()) begin
      if (stim_q[i] != SYNC) begin
        i++;
        continue;
      end
      if (i + 1 >= stim_q.size()) break;
      L = int'(stim_q[i+1]);
      if (L == 0 || L > MAX_LEN) begin
        exp_len_n++;
        i += 2;
        continue;
      end
      if (i + 2 + L >= stim_q.size()) break;
      s = L + int'(stim_q[i+2+L]);
      for (int j = 0; j < L; j++) s += int'(stim_q[i+2+j]);
      if (s % 256 == 0) begin
        for (int j = 0; j < L; j++) exp_q.push_back({(j == L - 1), stim_q[i+2+j]});
      end else begin
        exp_csum_n++;
      end
      i += L + 3;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    rx_par = b;
    rx_data_ready = 1'b1;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (rx_akn) done = 1'b1;
    end
    check("send_budget", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    rx_data_ready = 1'b0;
  endtask

  task automatic run_stream();
    model_push();
    foreach (stim_q[i]) begin
      send_byte(stim_q[i]);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    stim_q.delete();
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_budget", 32'(k < 3000), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_errs(input string tag);
    check({tag, "_err_len"},  32'(obs_len_n),  32'(exp_len_n));
    check({tag, "_err_csum"}, 32'(obs_csum_n), 32'(exp_csum_n));
    check({tag, "_err_tmo"},  32'(obs_tmo_n),  32'(exp_tmo_n));
  endtask

  task automatic gen_frame();
    int kind, L, s;
    logic [7:0] b;
    repeat ($urandom_range(0, 2)) begin
      b = 8'($urandom_range(0, 255));
      if (b == SYNC) b = 8'h00;
      stim_q.push_back(b);
    end
    kind = $urandom_range(0, 5);
    stim_q.push_back(SYNC);
    if (kind == 0) begin
      L = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
      stim_q.push_back(8'(L));
    end else begin
      L = $urandom_range(1, MAX_LEN);
      stim_q.push_back(8'(L));
      s = L;
      for (int j = 0; j < L; j++) begin
        b = 8'($urandom_range(0, 255));
        stim_q.push_back(b);
        s += int'(b);
      end
      b = 8'((256 - (s % 256)) % 256);
      if (kind == 1) b = b + 8'($urandom_range(1, 255));
      stim_q.push_back(b);
    end
  endtask

  initial begin
    int n0, first;
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, first;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_akn", 32'(rx_akn), 32'd0);
    check("rst_errs", 32'({err_len, err_csum, err_timeout}), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    n0 = n_cons;
    stim_q = {8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
    run_stream();
    wait_idle();
    check("good_consumed", 32'(n_cons - n0), 32'd5);
    check_errs("good");

    stim_q = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h81};
    run_stream();
    wait_idle();
    check_errs("junk");

    stim_q = {8'hA5, 8'h02, 8'h10, 8'h20, 8'hCF, 8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
    run_stream();
    wait_idle();
    check_errs("badcsum");

    stim_q = {8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h7E, 8'h81};
    run_stream();
    wait_idle();
    check_errs("badlen");

    rnd_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      for (int f = 0; f < 5; f++) gen_frame();
      run_stream();
      rnd_ready = 1'b0;
      out_ready = 1'b1;
      wait_idle();
      rnd_ready = 1'b1;
      check_errs("random");
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    stim_q = {8'hA5, 8'h02, 8'h10, 8'h20, 8'hCE};
    run_stream();
    rx_par = 8'h00;
    rx_data_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h10);
      check("bp_akn", 32'(rx_akn), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_byte(8'h00);
    wait_idle();
    check_errs("backpressure");

    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h01);
    exp_tmo_n++;
    first = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      if (err_timeout && first == 0) first = k;
    end
    check("tmo_latency", 32'(first), 32'(TMO));
    stim_q = {8'hA5, 8'h01, 8'h7E, 8'h81};
    run_stream();
    wait_idle();
    check_errs("timeout");

    out_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'hCE);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    stim_q = {8'hA5, 8'h02, 8'h33, 8'h44, 8'h87};
    run_stream();
    wait_idle();
    check_errs("midrst");
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_packet_parser.md
Name: uart_packet_parser

Overview:
Downstream consumer of the UART receiver. Takes received bytes over the receiver's ready/acknowledge handshake and hunts for framed packets of the form SYNC, LEN, LEN payload bytes, CSUM. It buffers the payload, checks the checksum, and streams only valid payloads out over a valid/ready interface with a last marker. Malformed, corrupt and stalled frames are dropped, and each drop raises a one-cycle error pulse.

Parameters:
DW, 8, byte width; must match the receiver's DW
SYNC_BYTE, 8'hA5, frame start marker
MAX_LEN, 16, maximum payload bytes; sizes the internal buffer (1..255)
TIMEOUT_CYCLES, 2000000, clk cycles allowed between accepted bytes while inside a frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst==0 resets on the clk rising edge)
rx_data_ready  in  1  receiver has a byte on rx_par
rx_par  in  DW  received byte
rx_akn  out  1  byte accepted this cycle (combinational)
out_data  out  DW  payload byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_last  out  1  final payload byte of the packet
err_len  out  1  one-cycle pulse: LEN was 0 or greater than MAX_LEN
err_csum  out  1  one-cycle pulse: checksum mismatch
err_timeout  out  1  one-cycle pulse: inter-byte timeout inside a frame

Behaviour:
- Reset (rst==0): state=HUNT; rx_akn=0; out_valid=0; out_last=0; out_data=0; all err_* =0; all counters and the checksum accumulator cleared. Reset applies in any state, including mid-frame or mid-drain; out_valid is 0 on the cycle after the reset edge.
- Byte acceptance: rx_akn = rx_data_ready & (state in HUNT/LEN/PAYLOAD/CSUM). A byte is consumed on the clk edge where rx_data_ready & rx_akn. The receiver clears its ready flag on the same edge, so each byte is consumed exactly once. In DRAIN rx_akn=0 and bytes are held upstream.
- Checksum: 8-bit accumulator, mod 2^8, cleared on entering LEN. It adds LEN, every payload byte and the CSUM byte. The frame is good iff the final sum ==0. For example, LEN=2, payload 10,20 gives CSUM=CE.
- States:
  - HUNT: a consumed byte equal to SYNC_BYTE moves to LEN. Any other byte is consumed and discarded silently.
  - LEN: a consumed byte of 0 or >MAX_LEN pulses err_len and moves to HUNT; that byte is not re-examined as SYNC. Otherwise store len, set idx=0 and move to PAYLOAD. A byte equal to SYNC_BYTE is treated as a length here.
  - PAYLOAD: each consumed byte is written to buf[idx] and idx increments. After byte idx==len-1 is consumed, move to CSUM.
  - CSUM: consume one byte. If sum==0, move to DRAIN with rd=0. Otherwise pulse err_csum and move to HUNT; the buffer is discarded.
  - DRAIN: out_valid=1, out_data=buf[rd], out_last=(rd==len-1). On out_valid & out_ready, rd increments; if the byte was last, move to HUNT. out_valid first asserts the cycle after the CSUM byte edge. out_data is held stable while out_valid & !out_ready.
- Timeout: the counter runs only in LEN/PAYLOAD/CSUM and clears on every consumed byte and on every state entry. If it reaches TIMEOUT_CYCLES-1 with no byte consumed, err_timeout pulses and the state moves to HUNT. There is no timeout in HUNT or DRAIN.
- Simultaneous events: if a byte is consumed on the same cycle the timeout would fire, the byte wins and the counter clears with no error. Only one err_* pulses per cycle.
- Error pulses are registered: high exactly one cycle, on the cycle after the causing edge.
- Widths: idx and rd are $clog2(MAX_LEN+1) bits. The timeout counter is $clog2(TIMEOUT_CYCLES) bits.

Test Plan:
- Good frame: A5,02,10,20,CE with out_ready=1 -> out_data 10 then 20 on consecutive valid cycles, out_last only on 20, no err_*; rx_akn high for exactly 5 consumed bytes.
- Junk then frame: 00,FF,A5,01,7E,81 -> the two junk bytes are consumed silently; one payload byte 7E is delivered with out_last=1.
- Bad checksum: A5,02,10,20,CF -> err_csum pulses once, out_valid never asserts. A following good frame is delivered normally.
- Bad length: A5,00 and A5,11 (MAX_LEN=16) -> err_len pulses each time, and the state is back in HUNT.
- Backpressure and timeout: good frame with out_ready=0 for 20 cycles -> out_data=10 held and rx_akn=0 throughout. With TIMEOUT_CYCLES=50, the sequence A5,03,01 followed by a stall -> err_timeout fires exactly 50 cycles after the last consumed byte.
- Reset mid-drain: drive rst=0 for one cycle while out_valid=1 -> out_valid=0 on the next cycle and state is HUNT; a following frame is parsed correctly.
